senone_score_store: RTL

//  Consumer end of the GDP score stream: captures each senone_score issued by gdp_controller

---
 rtl/senone_score_store_if.sv | 30 +++
 rtl/senone_score_store.sv | 133 +++++++++++++
 2 files changed

// File: rtl/senone_score_store_if.sv
// Score-stream and read-port bundle between gdp_controller, senone_score_store
// and the downstream search stage. The master drives the stream and the read
// requests. The slave is the score store itself.
interface senone_score_store_if #(
  parameter int SCORE_WIDTH = 16
);
  logic                          score_ready;
  logic [7:0]                    senone_idx;
  logic signed [SCORE_WIDTH-1:0] senone_score;
  logic                          last_senone;
  logic                          frame_ready;
  logic signed [SCORE_WIDTH-1:0] best_score;
  logic [7:0]                    best_idx;
  logic                          rd_en;
  logic [7:0]                    rd_idx;
  logic                          rd_valid;
  logic signed [SCORE_WIDTH-1:0] rd_score;
  logic                          frame_ack;
  logic                          err;

  modport master (
    output score_ready, senone_idx, senone_score, last_senone, rd_en, rd_idx, frame_ack,
    input  frame_ready, best_score, best_idx, rd_valid, rd_score, err
  );

  modport slave (
    input  score_ready, senone_idx, senone_score, last_senone, rd_en, rd_idx, frame_ack,
    output frame_ready, best_score, best_idx, rd_valid, rd_score, err
  );
endinterface

// File: rtl/senone_score_store.sv
// senone_score_store: per-frame senone score RAM with best-score tracking.
// A capture happens once on each rising edge of score_ready. On last_senone the
// frame is frozen and becomes readable. frame_ack releases the frame.
// Optional build macro SCORE_NORM_EN: when it is defined, the read data is
// RAM[idx] - best_score, saturated. When it is undefined, the read data is the raw RAM word.
//
// state   | meaning
// COLLECT | accepting scores for the current frame
// DONE    | frame complete, RAM/best frozen, reads honoured
module senone_score_store #(
  parameter int N_SENONES   = 10,
  parameter int SCORE_WIDTH = 16
) (
  input logic             clk,
  input logic             nreset,
  senone_score_store_if.slave bus
);
  localparam int AW = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DONE    = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic                          score_ready_q;
  logic [8:0]                    count_q, count_d;
  logic signed [SCORE_WIDTH-1:0] best_score_q, best_score_d;
  logic [7:0]                    best_idx_q, best_idx_d;
  logic                          err_q, err_d;
  logic                          rd_valid_q, rd_valid_d;
  logic signed [SCORE_WIDTH-1:0] rd_score_q, rd_score_d;
  logic signed [SCORE_WIDTH-1:0] mem [N_SENONES];

  logic                          score_edge, idx_ok, rd_idx_ok, capture, ack, rd_ok;
  logic [AW-1:0]                 wr_addr, rd_addr;
  logic signed [SCORE_WIDTH-1:0] rd_raw, rd_data;

  assign score_edge = bus.score_ready & ~score_ready_q;
  assign idx_ok     = int'(bus.senone_idx) < N_SENONES;
  assign rd_idx_ok  = int'(bus.rd_idx) < N_SENONES;
  assign capture    = score_edge && (state_q == COLLECT) && idx_ok;
  assign ack        = bus.frame_ack && (state_q == DONE);
  assign rd_ok      = bus.rd_en && (state_q == DONE) && rd_idx_ok;
  assign wr_addr    = bus.senone_idx[AW-1:0];
  assign rd_addr    = bus.rd_idx[AW-1:0];
  assign rd_raw     = mem[rd_addr];

`ifdef SCORE_NORM_EN
  logic signed [SCORE_WIDTH:0] norm_diff;
  assign norm_diff = {rd_raw[SCORE_WIDTH-1], rd_raw} - {best_score_q[SCORE_WIDTH-1], best_score_q};
  // The two top bits disagree only when the subtract leaves the score range.
  assign rd_data = (norm_diff[SCORE_WIDTH] != norm_diff[SCORE_WIDTH-1])
                 ? (norm_diff[SCORE_WIDTH] ? {1'b1, {(SCORE_WIDTH-1){1'b0}}}
                                           : {1'b0, {(SCORE_WIDTH-1){1'b1}}})
                 : norm_diff[SCORE_WIDTH-1:0];
`else
  assign rd_data = rd_raw;
`endif

  // Next-state logic for capture, best tracking, frame release and reads.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    err_d        = err_q;
    rd_valid_d   = rd_ok;
    rd_score_d   = rd_score_q;
    if (state_q == COLLECT) begin
      if (score_edge) begin
        if (!idx_ok) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q + 9'd1;
          // The first valid score always seeds best. Ties keep the earlier index.
          if ((count_q == 9'd0) || (bus.senone_score > best_score_q)) begin
            best_score_d = bus.senone_score;
            best_idx_d   = bus.senone_idx;
          end
        end
        if (bus.last_senone) begin
          state_d = DONE;
          if (count_d != 9'(N_SENONES)) err_d = 1'b1;
        end
      end
    end else begin
      if (ack) begin
        state_d      = COLLECT;
        count_d      = '0;
        best_score_d = '0;
        best_idx_d   = '0;
        err_d        = 1'b0;
      end
      // Overrun is flagged after an ack clear in the same cycle.
      if (score_edge) err_d = 1'b1;
    end
    if (bus.rd_en && !rd_idx_ok) err_d = 1'b1;
    if (rd_ok) rd_score_d = rd_data;
  end

  // Control and status registers, cleared by async reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= COLLECT;
      score_ready_q <= 1'b0;
      count_q       <= '0;
      best_score_q  <= '0;
      best_idx_q    <= '0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_score_q    <= '0;
    end else begin
      state_q       <= state_d;
      score_ready_q <= bus.score_ready;
      count_q       <= count_d;
      best_score_q  <= best_score_d;
      best_idx_q    <= best_idx_d;
      err_q         <= err_d;
      rd_valid_q    <= rd_valid_d;
      rd_score_q    <= rd_score_d;
    end
  end

  // Score RAM, deliberately not reset.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_addr] <= bus.senone_score;
  end

  assign bus.frame_ready = (state_q == DONE);
  assign bus.best_score  = best_score_q;
  assign bus.best_idx    = best_idx_q;
  assign bus.err         = err_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_score    = rd_score_q;
endmodule
